// File: rtl/add3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add3_seq_ctrl
//   Multi-precision adder front-end. A WIDTH-bit addition is performed by
//   time-sharing a single 3-bit full-adder slice (full_add_3b). The
//   controller processes one 3-bit digit per clock, LSB first, and chains
//   the carry between digits through a register.
//
//   Handshakes (both sides use the same valid/ready rule):
//     A transfer happens on a rising clk edge where valid && ready are both
//     high. The producer holds valid (and its payload) until that edge; the
//     consumer may drive ready at any time; neither side waits on the other
//     combinationally.
//     - start_valid/start_ready : operation request (a, b, cin payload)
//     - res_valid/res_ready     : result return (sum, cout, ovf payload)
//
//   Ports:
//     clk, rst_n           clock (rising edge), async active-low reset
//     start_valid/ready    operation request handshake
//     a, b, cin            operands, sampled only on acceptance
//     res_valid/ready      result handshake
//     sum                  registered WIDTH-bit result (modulo 2^WIDTH)
//     cout                 carry out of bit WIDTH-1
//     ovf                  signed overflow of the final digit
//     busy                 high while an operation is running or pending
//
//   FSM state is held in state_q (type state_e) for checker binding.
// ---------------------------------------------------------------------------

// 3-bit ripple full-adder slice.
//   a, b, cin -> sum[2:0], cout[2:0] (cout[i] = carry out of bit i)
module full_add_3b (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] sum,
  output logic [2:0] cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    cout  = '0;
    for (int i = 0; i < 3; i++) begin
      sum[i]  = a[i] ^ b[i] ^ carry;
      carry   = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
      cout[i] = carry;
    end
  end

endmodule

module add3_seq_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / 3;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_bad_width
      $error("add3_seq_ctrl: WIDTH must be a positive multiple of 3");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] a_q,         a_d;
  logic [WIDTH-1:0] b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [WIDTH-1:0] sum_q,       sum_d;
  logic             cout_q,      cout_d;
  logic             ovf_q,       ovf_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q,      busy_d;

  // Bit offset of the digit currently being added; widened to int so that
  // 3*idx cannot wrap inside the narrow idx width.
  int unsigned      base;
  logic [2:0]       slice_a;
  logic [2:0]       slice_b;
  logic [2:0]       slice_sum;
  logic [2:0]       slice_cout;

  assign base    = 32'(idx_q) * 32'd3;
  assign slice_a = a_q[base +: 3];
  assign slice_b = b_q[base +: 3];

  full_add_3b u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // Digits above idx keep the previous result until overwritten.
        sum_d[base +: 3] = slice_sum;
        carry_d          = slice_cout[2];
        if (idx_q == LAST_IDX) begin
          // carry into MSB xor carry out of MSB = two's-complement overflow
          cout_d      = slice_cout[2];
          ovf_d       = slice_cout[2] ^ slice_cout[1];
          idx_d       = '0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign res_valid   = res_valid_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_add3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add3_seq_ctrl
//   Bench for add3_seq_ctrl with WIDTH=12. Expected results ({cout, ovf,
//   sum}) come from an arithmetic model and are queued when an operation is
//   presented; they are popped when the DUT returns a result.
// ---------------------------------------------------------------------------
module tb_add3_seq_ctrl;

  localparam int W = 12;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];

  add3_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
    .ovf         (ovf),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {carry_out, signed_overflow, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {t[W], v, t[W-1:0]};
  endfunction

  function automatic logic [W+1:0] pop_exp();
    logic [W+1:0] e;
    e = {(W+2){1'bx}};
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Outputs must never be X/Z while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($isunknown({sum, cout, ovf, res_valid, busy, start_ready})) begin
        failures++;
        $display("FAIL xcheck: outputs unknown sum=%h cout=%b ovf=%b rv=%b",
                 sum, cout, ovf, res_valid);
      end
    end
  end

  // ---------------- driver ----------------
  // Presents one operation from IDLE, scrambles the operand inputs once it
  // is accepted, optionally toggles inputs during RUN, holds res_ready low
  // for `hold` cycles after res_valid, then takes the result. Called and
  // returns at posedge+1.
  task automatic drive_op(input  logic [W-1:0] ia,
                          input  logic [W-1:0] ib,
                          input  logic         ic,
                          input  int           hold,
                          input  bit           noisy,
                          output logic [W-1:0] osum,
                          output logic         ocout,
                          output logic         oovf,
                          output int           lat,
                          output bit           sr_high,
                          output bit           busy_low,
                          output bit           unstable);
    sr_high  = 1'b0;
    busy_low = 1'b0;
    unstable = 1'b0;
    lat      = -1;
    osum     = '0;
    ocout    = 1'b0;
    oovf     = 1'b0;
    a           = ia;
    b           = ib;
    cin         = ic;
    start_valid = 1'b1;
    res_ready   = 1'b0;
    exp_q.push_back(model(ia, ib, ic));
    @(posedge clk); #1;
    start_valid = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    for (int n = 1; n <= 20; n++) begin
      if (start_ready !== 1'b0) sr_high = 1'b1;
      if (busy !== 1'b1) busy_low = 1'b1;
      if (noisy) begin
        a           = W'($urandom);
        b           = W'($urandom);
        cin         = 1'($urandom);
        start_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (res_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    start_valid = 1'b0;
    if (lat < 0) return;
    if (start_ready !== 1'b0) sr_high = 1'b1;
    if (busy !== 1'b1) busy_low = 1'b1;
    osum  = sum;
    ocout = cout;
    oovf  = ovf;
    repeat (hold) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || sum !== osum || cout !== ocout || ovf !== oovf)
        unstable = 1'b1;
      if (start_ready !== 1'b0) sr_high = 1'b1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    #2;
    checks++;
    if ({start_ready, res_valid, busy, cout, ovf} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: got sr/rv/busy/cout/ovf=%b exp 10000",
               {start_ready, res_valid, busy, cout, ovf});
    end
    checks++;
    if (sum !== '0) begin
      failures++;
      $display("FAIL reset_sum: got %h exp 000", sum);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] s;
    logic         co, ov;
    logic [W+1:0] e;
    int           lat;
    bit           srh, bl, us;
    checks++;
    if (start_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle_ready: got %b exp 1", start_ready);
    end
    drive_op(12'h123, 12'h456, 1'b0, 0, 1'b0, s, co, ov, lat, srh, bl, us);
    e = pop_exp();
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL basic_latency: got %0d exp 4", lat);
    end
    checks++;
    if ({co, ov, s} !== e || e !== {1'b0, 1'b0, 12'h579}) begin
      failures++;
      $display("FAIL basic_result: got %h exp %h", {co, ov, s}, e);
    end
    checks++;
    if (srh !== 1'b0 || bl !== 1'b0) begin
      failures++;
      $display("FAIL basic_ready_busy: start_ready seen high=%b busy seen low=%b exp 0 0",
               srh, bl);
    end
  endtask

  task automatic test_carry_ripple();
    logic [W-1:0] ta[2] = '{12'hFFF, 12'h000};
    logic [W-1:0] tb[2] = '{12'h001, 12'h000};
    logic         tc[2] = '{1'b0, 1'b1};
    logic [W-1:0] s;
    logic         co, ov;
    logic [W+1:0] e;
    int           lat;
    bit           srh, bl, us;
    for (int i = 0; i < 2; i++) begin
      drive_op(ta[i], tb[i], tc[i], 0, 1'b0, s, co, ov, lat, srh, bl, us);
      e = pop_exp();
      checks++;
      if ({co, ov, s} !== e) begin
        failures++;
        $display("FAIL ripple_%0d: got cout/ovf/sum %h exp %h", i, {co, ov, s}, e);
      end
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL ripple_latency_%0d: got %0d exp 4", i, lat);
      end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta[3] = '{12'h7FF, 12'h800, 12'h8A3};
    logic [W-1:0] tb[3] = '{12'h001, 12'h800, 12'h75C};
    logic         tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] s;
    logic         co, ov;
    logic [W+1:0] e;
    int           lat;
    bit           srh, bl, us;
    for (int i = 0; i < 3; i++) begin
      drive_op(ta[i], tb[i], tc[i], 0, 1'b0, s, co, ov, lat, srh, bl, us);
      e = pop_exp();
      checks++;
      if ({co, ov, s} !== e) begin
        failures++;
        $display("FAIL overflow_%0d: got cout/ovf/sum %h exp %h", i, {co, ov, s}, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s;
    logic         co, ov;
    logic [W+1:0] e;
    int           lat;
    bit           srh, bl, us;
    for (int i = 0; i < 3; i++) begin
      drive_op(W'($urandom), W'($urandom), 1'($urandom), 3, 1'b1,
               s, co, ov, lat, srh, bl, us);
      e = pop_exp();
      checks++;
      if ({co, ov, s} !== e) begin
        failures++;
        $display("FAIL bp_result_%0d: got %h exp %h", i, {co, ov, s}, e);
      end
      checks++;
      if (us !== 1'b0 || srh !== 1'b0 || lat !== 4) begin
        failures++;
        $display("FAIL bp_stable_%0d: unstable=%b ready_high=%b lat=%0d exp 0 0 4",
                 i, us, srh, lat);
      end
      @(posedge clk); #1;
      checks++;
      if ({res_valid, busy, start_ready} !== 3'b001 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL bp_no_second_accept_%0d: rv/busy/sr=%b q=%0d exp 001 0",
                 i, {res_valid, busy, start_ready}, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s;
    logic         co, ov;
    logic [W+1:0] e;
    int           lat;
    bit           srh, bl, us;
    a           = 12'h123;
    b           = 12'h456;
    cin         = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start_ready, res_valid, busy, cout, ovf} !== 5'b10000 || sum !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: sr/rv/busy/cout/ovf=%b sum=%h exp 10000 000",
               {start_ready, res_valid, busy, cout, ovf}, sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_aborted: rv=%b sr=%b exp 0 1", res_valid, start_ready);
    end
    drive_op(12'h00A, 12'h005, 1'b0, 0, 1'b0, s, co, ov, lat, srh, bl, us);
    e = pop_exp();
    checks++;
    if ({co, ov, s} !== e || s !== 12'h00F || lat !== 4) begin
      failures++;
      $display("FAIL midreset_recover: got %h lat=%0d exp %h lat=4",
               {co, ov, s}, lat, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta[3] = '{12'hABC, 12'hFFF, 12'h3E1};
    logic [W-1:0] tb[3] = '{12'h123, 12'hFFF, 12'h41F};
    logic         tc[3] = '{1'b1, 1'b1, 1'b0};
    int           acc_cyc[3] = '{0, 0, 0};
    int           nacc = 0;
    int           npop = 0;
    int           cyc  = 0;
    bit           acc;
    logic [W+1:0] e;
    a           = ta[0];
    b           = tb[0];
    cin         = tc[0];
    start_valid = 1'b1;
    res_ready   = 1'b1;
    exp_q.push_back(model(ta[0], tb[0], tc[0]));
    while (npop < 3 && cyc < 60) begin
      acc = (start_valid === 1'b1) && (start_ready === 1'b1);
      if (res_valid === 1'b1) begin
        e = pop_exp();
        checks++;
        if ({cout, ovf, sum} !== e) begin
          failures++;
          $display("FAIL b2b_result_%0d: got %h exp %h", npop, {cout, ovf, sum}, e);
        end
        npop++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (nacc < 3) acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc < 3) begin
          a   = ta[nacc];
          b   = tb[nacc];
          cin = tc[nacc];
          exp_q.push_back(model(ta[nacc], tb[nacc], tc[nacc]));
        end else begin
          start_valid = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    checks++;
    if (npop !== 3 || nacc !== 3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: results=%0d accepts=%0d left=%0d exp 3 3 0",
               npop, nacc, exp_q.size());
    end
    checks++;
    if (acc_cyc[1] - acc_cyc[0] !== 6 || acc_cyc[2] - acc_cyc[1] !== 6) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d %0d exp 6 6",
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
    checks++;
    if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle: rv=%b sr=%b exp 0 1", res_valid, start_ready);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_carry_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
